fpu_ret_collect: RTL and testbench



---
 rtl/fpu_ret_collect.sv | 118 +++++++++++
 tb/tb_fpu_ret_collect.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_ret_collect.sv
// rtl/fpu_ret_collect.sv - six-lane FP return collector: lane-tagged compaction into a circular FIFO, dual-slot drain
// Overflowing lanes are dropped highest-first and latch ovf_err; fpu_stall is registered from next occupancy.
module fpu_ret_collect #(
  parameter int DEPTH     = 32,
  parameter int STALL_THR = DEPTH - 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [13:0]               u1_ret,
  input  logic [13:0]               u2_ret,
  input  logic [13:0]               u3_ret,
  input  logic [13:0]               u4_ret,
  input  logic [13:0]               u5_ret,
  input  logic [13:0]               u6_ret,
  input  logic                      u1_ret_en,
  input  logic                      u2_ret_en,
  input  logic                      u3_ret_en,
  input  logic                      u4_ret_en,
  input  logic                      u5_ret_en,
  input  logic                      u6_ret_en,
  input  logic                      out_ready,
  output logic                      out0_valid,
  output logic [16:0]               out0_data,
  output logic                      out1_valid,
  output logic [16:0]               out1_data,
  output logic                      fpu_stall,
  output logic                      ovf_err,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] THR_W   = CW'(STALL_THR);

  logic [16:0]   r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_stall;
  logic          r_ovf;

  logic [5:0]    w_en;
  logic [13:0]   w_ret [6];
  logic [1:0]    w_pops;
  logic [CW:0]   w_free;
  logic [2:0]    w_push;
  logic          w_drop;
  logic          w_wr_en   [6];
  logic [AW-1:0] w_wr_addr [6];
  logic [16:0]   w_wr_data [6];
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_head1;

  assign w_en     = {u6_ret_en, u5_ret_en, u4_ret_en, u3_ret_en, u2_ret_en, u1_ret_en};
  assign w_ret[0] = u1_ret;
  assign w_ret[1] = u2_ret;
  assign w_ret[2] = u3_ret;
  assign w_ret[3] = u4_ret;
  assign w_ret[4] = u5_ret;
  assign w_ret[5] = u6_ret;

  assign out0_valid = (r_count != '0);
  assign out1_valid = (r_count[CW-1:1] != '0);
  assign w_head1    = r_head + {{(AW-1){1'b0}}, 1'b1};
  assign out0_data  = r_mem[r_head];
  assign out1_data  = r_mem[w_head1];

  assign w_pops = out_ready ? ({1'b0, out0_valid} + {1'b0, out1_valid}) : 2'd0;
  // Slots popped this cycle are reusable by this cycle's pushes.
  assign w_free = DEPTH_W - {1'b0, r_count} + {{(CW-1){1'b0}}, w_pops};

  always_comb begin
    w_push = 3'd0;
    w_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w_wr_en[i]   = 1'b0;
      w_wr_addr[i] = r_tail;
      w_wr_data[i] = {3'(i + 1), w_ret[i]};
      if (w_en[i]) begin
        if ({{(CW-2){1'b0}}, w_push} < w_free) begin
          w_wr_en[i]   = 1'b1;
          w_wr_addr[i] = r_tail + {{(AW-3){1'b0}}, w_push};
          w_push       = w_push + 3'd1;
        end else begin
          w_drop = 1'b1;
        end
      end
    end
  end

  assign w_count_next = r_count + {{(CW-3){1'b0}}, w_push} - {{(CW-2){1'b0}}, w_pops};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (w_wr_en[i]) r_mem[w_wr_addr[i]] <= w_wr_data[i];
      end
      r_head  <= r_head + {{(AW-2){1'b0}}, w_pops};
      r_tail  <= r_tail + {{(AW-3){1'b0}}, w_push};
      r_count <= w_count_next;
      r_stall <= (w_count_next > THR_W);
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign fpu_stall = r_stall;
  assign ovf_err   = r_ovf;
  assign count     = r_count;

endmodule

// File: tb/tb_fpu_ret_collect.sv
// tb/tb_fpu_ret_collect.sv - directed bench for fpu_ret_collect with a queue reference model
module tb_fpu_ret_collect;

  localparam int DEPTH = 32;
  localparam int THR   = DEPTH - 12;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] ret_v [1:6];
  logic [6:1]  en_v;
  logic        out_ready;
  logic        out0_valid, out1_valid, fpu_stall, ovf_err;
  logic [16:0] out0_data, out1_data;
  logic [5:0]  count;

  logic [16:0] q [$];
  logic        m_ovf;
  int          seq;
  int          n_total;
  int          n_bad;

  always #5 clk = ~clk;

  fpu_ret_collect #(.DEPTH(DEPTH), .STALL_THR(THR)) dut (
    .clk(clk), .rst(rst),
    .u1_ret(ret_v[1]), .u2_ret(ret_v[2]), .u3_ret(ret_v[3]),
    .u4_ret(ret_v[4]), .u5_ret(ret_v[5]), .u6_ret(ret_v[6]),
    .u1_ret_en(en_v[1]), .u2_ret_en(en_v[2]), .u3_ret_en(en_v[3]),
    .u4_ret_en(en_v[4]), .u5_ret_en(en_v[5]), .u6_ret_en(en_v[6]),
    .out_ready(out_ready),
    .out0_valid(out0_valid), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_data(out1_data),
    .fpu_stall(fpu_stall), .ovf_err(ovf_err), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic auto_rets();
    for (int l = 1; l <= 6; l++) ret_v[l] = 14'((seq << 3) | l);
    seq++;
  endtask

  task automatic step(input logic [6:1] mask, input logic rdy);
    int pops, free, pushes;
    en_v      = mask;
    out_ready = rdy;
    pops   = rdy ? ((q.size() >= 2) ? 2 : q.size()) : 0;
    free   = DEPTH - q.size() + pops;
    pushes = 0;
    for (int p = 0; p < pops; p++) void'(q.pop_front());
    for (int l = 1; l <= 6; l++) begin
      if (mask[l]) begin
        if (pushes < free) begin
          q.push_back({3'(l), ret_v[l]});
          pushes++;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(q.size()));
    chk("out0_valid", 32'(out0_valid), 32'(q.size() >= 1));
    chk("out1_valid", 32'(out1_valid), 32'(q.size() >= 2));
    if (q.size() >= 1) chk("out0_data", 32'(out0_data), 32'(q[0]));
    if (q.size() >= 2) chk("out1_data", 32'(out1_data), 32'(q[1]));
    chk("fpu_stall", 32'(fpu_stall), 32'(q.size() > THR));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_v0", 32'(out0_valid), 32'd0);
    chk("rst_v1", 32'(out1_valid), 32'd0);
    chk("rst_stall", 32'(fpu_stall), 32'd0);
    chk("rst_ovf", 32'(ovf_err), 32'd0);
    q.delete();
    m_ovf     = 1'b0;
    en_v      = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0; seq = 0; m_ovf = 1'b0;
    rst = 1'b0; en_v = '0; out_ready = 1'b0;
    for (int l = 1; l <= 6; l++) ret_v[l] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_count", 32'(count), 32'd0);
    chk("init_v0", 32'(out0_valid), 32'd0);
    chk("init_data0", 32'(out0_data), 32'd0);
    chk("init_stall", 32'(fpu_stall), 32'd0);
    chk("init_ovf", 32'(ovf_err), 32'd0);
    rst = 1'b1;

    // Lanes 2 and 5 compact into adjacent entries
    ret_v[2] = 14'h0A1;
    ret_v[5] = 14'h1FF;
    step(6'b010010, 1'b0);
    chk("t1_out0", 32'(out0_data), 32'h080A1);
    chk("t1_out1", 32'(out1_data), 32'h141FF);
    chk("t1_count", 32'(count), 32'd2);
    do_reset();

    for (int c = 0; c < 4; c++) begin
      auto_rets();
      step(6'b111111, 1'b0);
    end
    chk("t2_count", 32'(count), 32'd24);
    chk("t2_stall", 32'(fpu_stall), 32'd1);
    chk("t2_ovf", 32'(ovf_err), 32'd0);

    // Full FIFO, two pops and six pushes: only lanes 1-2 fit
    auto_rets();
    step(6'b111111, 1'b0);
    auto_rets();
    step(6'b000011, 1'b0);
    chk("t3_full", 32'(count), 32'd32);
    auto_rets();
    step(6'b111111, 1'b1);
    chk("t3_count", 32'(count), 32'd32);
    chk("t3_ovf", 32'(ovf_err), 32'd1);
    step(6'b000000, 1'b0);
    chk("t3_ovf_sticky", 32'(ovf_err), 32'd1);
    repeat (16) step(6'b000000, 1'b1);
    chk("t3_drained", 32'(count), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ret_v[3] = 14'(100 + i);
      step(6'b000100, 1'b1);
      chk("t4_cnt_le1", 32'(count <= 6'd1), 32'd1);
      chk("t4_head", 32'(out0_data), {15'd0, 3'd3, 14'(100 + i)});
    end
    step(6'b000000, 1'b1);
    chk("t4_ovf_still", 32'(ovf_err), 32'd1);
    do_reset();

    // Move pointers to 30 so the 5-entry load straddles the wrap
    for (int c = 0; c < 5; c++) begin
      auto_rets();
      step(6'b111111, 1'b0);
    end
    repeat (15) step(6'b000000, 1'b1);
    auto_rets();
    step(6'b011111, 1'b0);
    chk("t5_load", 32'(count), 32'd5);
    step(6'b000000, 1'b1);
    chk("t5_pop2a", 32'(count), 32'd3);
    step(6'b000000, 1'b1);
    chk("t5_pop2b", 32'(count), 32'd1);
    chk("t5_single_v1", 32'(out1_valid), 32'd0);
    step(6'b000000, 1'b1);
    chk("t5_empty", 32'(count), 32'd0);
    step(6'b000000, 1'b1);

    for (int c = 0; c < 5; c++) begin
      auto_rets();
      step(6'b111111, 1'b0);
    end
    auto_rets();
    step(6'b111111, 1'b0);
    chk("t6_count", 32'(count), 32'd32);
    chk("t6_ovf", 32'(ovf_err), 32'd1);
    chk("t6_stall", 32'(fpu_stall), 32'd1);
    do_reset();
    ret_v[4] = 14'h2AB;
    step(6'b001000, 1'b0);
    chk("t6_after_rst", 32'(out0_data), 32'h102AB);
    chk("t6_after_cnt", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
